// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: two-entry skid buffer between pipeline stages.
//   Holds up to two payloads (main drives out_data, skid catches the one
//   that arrives while downstream stalls). in_ready is decoded from
//   registered state only, so there is no combinational path from
//   out_ready to in_ready.
// Ports:
//   clk        - clock, all state changes on rising edge
//   reset      - synchronous active-low reset
//   flush      - synchronous discard of all held entries (main/skid -> 0)
//   in_valid   - upstream payload valid
//   in_ready   - stage can accept a payload this cycle
//   in_data    - upstream payload
//   out_valid  - out_data holds a valid payload
//   out_ready  - downstream accepts out_data (0 = stall)
//   out_data   - payload to downstream (main entry)
//   occupancy  - number of held entries (0..2)
//   stall_cnt  - saturating count of cycles with out_valid=1, out_ready=0
module pipe_skid_stage #(
  parameter int unsigned DATA_W = 96,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  main_q, main_d;
  logic [DATA_W-1:0]  skid_q, skid_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               in_xfer, out_xfer;

  // Handshake outputs are pure decodes of the registered state.
  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;
  assign occupancy = state_q;
  assign stall_cnt = cnt_q;

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    cnt_d   = cnt_q;

    case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          state_d = ONE;
          main_d  = in_data;
        end
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          main_d = in_data;
        end else if (in_xfer) begin
          state_d = FULL;
          skid_d  = in_data;
        end else if (out_xfer) begin
          // Drain: main keeps its last value.
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_xfer) begin
          state_d = ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase

    // Flush wins over any transfer in the same cycle.
    if (flush) begin
      state_d = EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end

    // Stall counter ignores flush; saturates at all-ones.
    if (out_valid && !out_ready && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// tb_pipe_skid_stage: vector table for directed cases, hand-written stall
// saturation sequence, and a random run against a queue reference model.
module tb_pipe_skid_stage;

  localparam int unsigned DW = 16;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          reset, flush, in_valid, out_ready;
  logic          in_ready, out_valid;
  logic [DW-1:0] in_data, out_data;
  logic [1:0]    occupancy;
  logic [CW-1:0] stall_cnt;

  pipe_skid_stage #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: queue of held payloads (scoreboard), stall counter,
  // and a flag meaning "main was zeroed by reset/flush and not yet reloaded".
  logic [DW-1:0] mq[$];
  int unsigned   mcnt;
  bit            mzero;

  typedef struct {
    logic          rst, fl, iv;
    logic [DW-1:0] din;
    logic          ordy;
    logic          ev, er;
    logic [1:0]    eo;
    logic          chkd;
    logic [DW-1:0] ed;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a negedge: drive inputs, compare DUT against the model,
  // advance the model, then move to the next negedge.
  task automatic step(input logic r, input logic f, input logic v,
                      input logic [DW-1:0] d, input logic o);
    bit ox, ix, stalled;
    reset = r; flush = f; in_valid = v; in_data = d; out_ready = o;
    #1;
    chk("out_valid", {31'd0, out_valid}, {31'd0, mq.size() != 0});
    chk("in_ready", {31'd0, in_ready}, {31'd0, mq.size() < 2});
    chk("occupancy", {30'd0, occupancy}, mq.size());
    chk("stall_cnt", {28'd0, stall_cnt}, mcnt);
    if (mq.size() != 0) chk("sb_data", {16'd0, out_data}, {16'd0, mq[0]});
    else if (mzero) chk("zero_data", {16'd0, out_data}, 32'd0);

    stalled = (mq.size() != 0) && !o;
    if (!r) begin
      mq.delete();
      mcnt  = 0;
      mzero = 1'b1;
    end else begin
      if (stalled && mcnt != 15) mcnt++;
      if (f) begin
        mq.delete();
        mzero = 1'b1;
      end else begin
        ox = (mq.size() != 0) && o;
        ix = v && (mq.size() < 2);
        if (ox) void'(mq.pop_front());
        if (ix) begin
          mq.push_back(d);
          mzero = 1'b0;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic vec_t mk(logic rst, logic fl, logic iv, logic [DW-1:0] din,
                              logic ordy, logic ev, logic er, logic [1:0] eo,
                              logic chkd, logic [DW-1:0] ed);
    vec_t t;
    t.rst = rst; t.fl = fl; t.iv = iv; t.din = din; t.ordy = ordy;
    t.ev = ev; t.er = er; t.eo = eo; t.chkd = chkd; t.ed = ed;
    return t;
  endfunction

  initial begin
    // Expected outputs are those seen one cycle after the vector's inputs.
    //                 rst fl iv din       ordy  ev   er   eo  chkd ed
    tbl.push_back(mk(0, 0, 0, 16'h0000, 1,   0,   1,   0,  1, 16'h0000)); // reset
    tbl.push_back(mk(1, 0, 1, 16'h00A5, 1,   1,   1,   1,  1, 16'h00A5));
    tbl.push_back(mk(1, 0, 0, 16'h0000, 1,   0,   1,   0,  0, 16'h0000));
    tbl.push_back(mk(1, 0, 1, 16'h0001, 1,   1,   1,   1,  1, 16'h0001)); // stream
    tbl.push_back(mk(1, 0, 1, 16'h0002, 1,   1,   1,   1,  1, 16'h0002));
    tbl.push_back(mk(1, 0, 1, 16'h0003, 1,   1,   1,   1,  1, 16'h0003));
    tbl.push_back(mk(1, 0, 1, 16'h0004, 1,   1,   1,   1,  1, 16'h0004));
    tbl.push_back(mk(1, 0, 0, 16'h0000, 1,   0,   1,   0,  0, 16'h0000));
    tbl.push_back(mk(1, 0, 1, 16'h0010, 0,   1,   1,   1,  1, 16'h0010)); // skid fill
    tbl.push_back(mk(1, 0, 1, 16'h0011, 0,   1,   0,   2,  1, 16'h0010));
    tbl.push_back(mk(1, 0, 1, 16'h0012, 0,   1,   0,   2,  1, 16'h0010)); // FULL holds
    tbl.push_back(mk(1, 0, 0, 16'h0000, 1,   1,   1,   1,  1, 16'h0011));
    tbl.push_back(mk(1, 0, 0, 16'h0000, 1,   0,   1,   0,  0, 16'h0000));
    tbl.push_back(mk(1, 0, 1, 16'h0020, 0,   1,   1,   1,  1, 16'h0020)); // flush in FULL
    tbl.push_back(mk(1, 0, 1, 16'h0021, 0,   1,   0,   2,  1, 16'h0020));
    tbl.push_back(mk(1, 1, 1, 16'h0099, 1,   0,   1,   0,  1, 16'h0000));
    tbl.push_back(mk(1, 0, 0, 16'h0000, 1,   0,   1,   0,  1, 16'h0000));
    tbl.push_back(mk(1, 0, 1, 16'h0030, 0,   1,   1,   1,  1, 16'h0030)); // reset in FULL
    tbl.push_back(mk(1, 0, 1, 16'h0031, 0,   1,   0,   2,  1, 16'h0030));
    tbl.push_back(mk(0, 0, 1, 16'h0032, 1,   0,   1,   0,  1, 16'h0000));
    tbl.push_back(mk(1, 0, 0, 16'h0000, 1,   0,   1,   0,  1, 16'h0000));

    // Bring the DUT out of its unknown power-up state before any check.
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    mq.delete();
    mcnt  = 0;
    mzero = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rst, tbl[i].fl, tbl[i].iv, tbl[i].din, tbl[i].ordy);
      chk($sformatf("vec%0d_valid", i), {31'd0, out_valid}, {31'd0, tbl[i].ev});
      chk($sformatf("vec%0d_ready", i), {31'd0, in_ready}, {31'd0, tbl[i].er});
      chk($sformatf("vec%0d_occ", i), {30'd0, occupancy}, {30'd0, tbl[i].eo});
      if (tbl[i].chkd) chk($sformatf("vec%0d_data", i), {16'd0, out_data}, {16'd0, tbl[i].ed});
    end

    // Stall counter saturation, survives flush, cleared by reset.
    step(0, 0, 0, 16'h0000, 1);
    step(1, 0, 1, 16'h0040, 0);
    for (int i = 0; i < 20; i++) step(1, 0, 0, 16'h0000, 0);
    chk("stall_sat", {28'd0, stall_cnt}, 32'd15);
    step(1, 1, 0, 16'h0000, 0);
    chk("stall_after_flush", {28'd0, stall_cnt}, 32'd15);
    chk("occ_after_flush", {30'd0, occupancy}, 32'd0);
    step(0, 0, 0, 16'h0000, 0);
    chk("stall_after_reset", {28'd0, stall_cnt}, 32'd0);

    // Random traffic against the queue model.
    for (int i = 0; i < 10000; i++) begin
      step(($urandom_range(0, 499) != 0),
           ($urandom_range(0, 63) == 0),
           ($urandom_range(0, 2) != 0),
           16'($urandom()),
           ($urandom_range(0, 3) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
